// File: rtl/icache_sa.sv
// icache_sa: set-associative read-only instruction cache with round-robin replacement and flush
// Ports: clk_i/rst_ni clock and async active-low reset; rdy_i global enable;
//   req_i/addr_i/flush_i fetch side in; data_out_o/busy_o/done_o fetch side out;
//   mem_rw_flag_o/mem_addr_o/mem_len_o refill request; mem_data_i/mem_busy_i/mem_done_i refill response.
module icache_sa #(
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rdy_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        mem_rw_flag_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [1:0]        mem_len_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_busy_i,
  input  logic              mem_done_i
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam int PW    = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  logic [SETS-1:0][PW-1:0]   ptr_q, ptr_d;
  logic [TAG_W-1:0]  tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0] data_mem [SETS][WAYS];
  logic [TAG_W-1:0]  tag_l_q, tag_l_d;
  logic [IDX_W-1:0]  idx_l_q, idx_l_d;
  logic [PW-1:0]     way_l_q, way_l_d;
  logic              from_ptr_q, from_ptr_d, discard_q, discard_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              done_q, done_d;
  logic [1:0]        rw_q, rw_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit, inv, wr_en;
  logic [PW-1:0]     hit_way, inv_way;
  logic              unused_ok;
  assign idx = addr_i[IDX_W+1:2];
  assign tag = addr_i[ADDR_W-1:IDX_W+2];
  assign unused_ok = ^{mem_busy_i, addr_i[1:0]};
  // Descending scan leaves the lowest-numbered invalid way as the victim candidate.
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx][w] && tag_mem[idx][w] == tag) begin
        hit = 1'b1;
        hit_way = PW'(w);
      end
      if (!valid_q[idx][w]) begin
        inv = 1'b1;
        inv_way = PW'(w);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ptr_d = ptr_q;
    tag_l_d = tag_l_q;
    idx_l_d = idx_l_q;
    way_l_d = way_l_q;
    from_ptr_d = from_ptr_q;
    discard_d = discard_q;
    data_out_d = data_out_q;
    done_d = 1'b0;
    rw_d = 2'b00;
    maddr_d = maddr_q;
    wr_en = 1'b0;
    if (state_q == IDLE) begin
      if (flush_i) begin
        valid_d = '0;
        ptr_d = '0;
      end else if (req_i && hit) begin
        done_d = 1'b1;
        data_out_d = data_mem[idx][hit_way];
      end else if (req_i) begin
        rw_d = 2'b01;
        maddr_d = {addr_i[ADDR_W-1:2], 2'b00};
        state_d = BUSY;
        tag_l_d = tag;
        idx_l_d = idx;
        way_l_d = inv ? inv_way : (WAYS > 1 ? ptr_q[idx] : '0);
        from_ptr_d = !inv;
      end
    end else begin
      // A flush during refill wipes the cache now and keeps the returning word out of it.
      if (flush_i) begin
        valid_d = '0;
        ptr_d = '0;
        discard_d = 1'b1;
      end
      if (mem_done_i) begin
        data_out_d = mem_data_i;
        done_d = 1'b1;
        state_d = IDLE;
        discard_d = 1'b0;
        if (!discard_q && !flush_i) begin
          wr_en = 1'b1;
          valid_d[idx_l_q][way_l_q] = 1'b1;
          if (from_ptr_q) ptr_d[idx_l_q] = ptr_q[idx_l_q] + 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= '0;
      ptr_q <= '0;
      tag_l_q <= '0;
      idx_l_q <= '0;
      way_l_q <= '0;
      from_ptr_q <= 1'b0;
      discard_q <= 1'b0;
      data_out_q <= '0;
      done_q <= 1'b0;
      rw_q <= 2'b00;
      maddr_q <= '0;
    end else if (rdy_i) begin
      state_q <= state_d;
      valid_q <= valid_d;
      ptr_q <= ptr_d;
      tag_l_q <= tag_l_d;
      idx_l_q <= idx_l_d;
      way_l_q <= way_l_d;
      from_ptr_q <= from_ptr_d;
      discard_q <= discard_d;
      data_out_q <= data_out_d;
      done_q <= done_d;
      rw_q <= rw_d;
      maddr_q <= maddr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rdy_i && wr_en) begin
      tag_mem[idx_l_q][way_l_q] <= tag_l_q;
      data_mem[idx_l_q][way_l_q] <= mem_data_i;
    end
  end
  assign data_out_o = data_out_q;
  assign busy_o = state_q == BUSY;
  assign done_o = done_q;
  assign mem_rw_flag_o = rw_q;
  assign mem_addr_o = maddr_q;
  assign mem_len_o = {2{|rw_q}};
endmodule

// File: tb/tb_icache_sa.sv
// tb_icache_sa: scoreboard-driven bench for icache_sa
module tb_icache_sa;
  logic clk = 0, rst_n = 0, rdy = 1, req = 0, flush = 0, mem_done = 0, mem_busy = 0;
  logic [31:0] addr = 0, mem_data = 0;
  logic [31:0] data_out, mem_addr;
  logic busy, done;
  logic [1:0] mem_rw_flag, mem_len;
  int passed = 0, total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  icache_sa dut (
    .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .req_i(req), .addr_i(addr), .flush_i(flush),
    .data_out_o(data_out), .busy_o(busy), .done_o(done), .mem_rw_flag_o(mem_rw_flag),
    .mem_addr_o(mem_addr), .mem_len_o(mem_len), .mem_data_i(mem_data), .mem_busy_i(mem_busy),
    .mem_done_i(mem_done)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end
  function automatic logic [31:0] word(input logic [31:0] a);
    return a == 32'h1000 ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  task automatic fetch(input logic [31:0] a, input bit hit, input string nm);
    @(negedge clk); req = 1; addr = a; exp_q.push_back(word(a));
    @(posedge clk); #1;
    if (hit) begin
      total++;
      if (done !== 1'b1 || mem_rw_flag !== 2'b00) $display("FAIL %s hit: done=%b rw=%b, want done=1 rw=00", nm, done, mem_rw_flag);
      else passed++;
    end else begin
      total++;
      if (done !== 1'b0 || mem_rw_flag !== 2'b01 || mem_addr !== {a[31:2], 2'b00} || mem_len !== 2'b11 || busy !== 1'b1)
        $display("FAIL %s miss_req: done=%b rw=%b addr=%h len=%b busy=%b, want 0 01 %h 11 1", nm, done, mem_rw_flag, mem_addr, mem_len, busy, {a[31:2], 2'b00});
      else passed++;
      @(negedge clk); addr = 32'hFFFF_FFFC;
      @(posedge clk); #1;
      total++;
      if (mem_rw_flag !== 2'b00 || busy !== 1'b1 || done !== 1'b0) $display("FAIL %s wait: rw=%b busy=%b done=%b, want 00 1 0", nm, mem_rw_flag, busy, done);
      else passed++;
      @(negedge clk); mem_done = 1; mem_data = word(a);
      @(posedge clk); #1;
      total++;
      if (done !== 1'b1 || busy !== 1'b0) $display("FAIL %s refill_done: done=%b busy=%b, want 1 0", nm, done, busy);
      else passed++;
    end
    e = exp_q.pop_front();
    total++;
    if (data_out !== e) $display("FAIL %s data: got %h want %h", nm, data_out, e);
    else passed++;
    @(negedge clk); req = 0; mem_done = 0; addr = 0;
  endtask
  task automatic do_flush();
    @(negedge clk); flush = 1;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL flush: done=%b busy=%b, want 0 0", done, busy);
    else passed++;
    @(negedge clk); flush = 0;
  endtask
  task automatic test_reset();
    #1;
    total++;
    if (data_out !== 0 || busy !== 0 || done !== 0 || mem_rw_flag !== 0 || mem_addr !== 0 || mem_len !== 0)
      $display("FAIL reset: data=%h busy=%b done=%b rw=%b addr=%h len=%b, want all 0", data_out, busy, done, mem_rw_flag, mem_addr, mem_len);
    else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_miss_hit();
    fetch(32'h1000, 0, "first_miss");
    fetch(32'h1000, 1, "first_hit");
  endtask
  task automatic test_round_robin();
    do_flush();
    fetch(32'h1000, 0, "rr_1000");
    fetch(32'h1100, 0, "rr_1100");
    fetch(32'h1200, 0, "rr_1200");
    fetch(32'h1100, 1, "rr_hit_1100");
    fetch(32'h1200, 1, "rr_hit_1200");
    fetch(32'h1000, 0, "rr_evicted_1000");
    fetch(32'h1100, 0, "rr_evicted_1100");
    fetch(32'h1000, 1, "rr_hit_1000");
  endtask
  task automatic test_flush();
    fetch(32'h1000, 1, "pre_flush_hit");
    do_flush();
    fetch(32'h1000, 0, "post_flush_miss");
  endtask
  task automatic test_flush_busy();
    @(negedge clk); req = 1; addr = 32'h2000; exp_q.push_back(word(32'h2000));
    @(posedge clk); #1;
    total++;
    if (mem_rw_flag !== 2'b01 || busy !== 1'b1) $display("FAIL fb_req: rw=%b busy=%b, want 01 1", mem_rw_flag, busy);
    else passed++;
    @(negedge clk); flush = 1;
    @(posedge clk); #1;
    @(negedge clk); flush = 0; mem_done = 1; mem_data = word(32'h2000);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (done !== 1'b1 || data_out !== e) $display("FAIL fb_deliver: done=%b data=%h, want 1 %h", done, data_out, e);
    else passed++;
    @(negedge clk); req = 0; mem_done = 0;
    fetch(32'h1000, 0, "fb_1000_cleared");
    fetch(32'h2000, 0, "fb_2000_not_installed");
  endtask
  task automatic test_rdy_hold();
    @(negedge clk); req = 1; addr = 32'h2000; exp_q.push_back(word(32'h2000));
    @(posedge clk); #1;
    total++;
    if (done !== 1'b1) $display("FAIL rdy_hit: done=%b, want 1", done);
    else passed++;
    @(negedge clk); rdy = 0; req = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (done !== 1'b1 || data_out !== exp_q[0]) $display("FAIL rdy_hold%0d: done=%b data=%h, want 1 %h", i, done, data_out, exp_q[0]);
      else passed++;
    end
    @(negedge clk); rdy = 1;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    total++;
    if (done !== 1'b0 || data_out !== e) $display("FAIL rdy_resume: done=%b data=%h, want 0 %h", done, data_out, e);
    else passed++;
  endtask
  task automatic test_reset_mid();
    @(negedge clk); req = 1; addr = 32'h3000;
    @(posedge clk); #1;
    total++;
    if (mem_rw_flag !== 2'b01) $display("FAIL rm_req: rw=%b, want 01", mem_rw_flag);
    else passed++;
    rst_n = 0;
    #1;
    total++;
    if (data_out !== 0 || busy !== 0 || done !== 0 || mem_rw_flag !== 0 || mem_addr !== 0 || mem_len !== 0)
      $display("FAIL rm_async: data=%h busy=%b done=%b rw=%b addr=%h len=%b, want all 0", data_out, busy, done, mem_rw_flag, mem_addr, mem_len);
    else passed++;
    @(negedge clk); req = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk); mem_done = 1; mem_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    total++;
    if (done !== 0 || busy !== 0 || data_out !== 0) $display("FAIL rm_stale_done: done=%b busy=%b data=%h, want 0 0 0", done, busy, data_out);
    else passed++;
    @(negedge clk); mem_done = 0;
    fetch(32'h1000, 0, "rm_1000_miss");
    fetch(32'h1000, 1, "rm_1000_hit");
  endtask
  initial begin
    test_reset();
    test_miss_hit();
    test_round_robin();
    test_flush();
    test_flush_busy();
    test_rdy_hold();
    fetch(32'h1000, 1, "pre_reset_hit");
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative, read-only instruction cache between the fetch stage and the memory controller. Lookups complete in one cycle on a hit. A miss issues a single-word read to the memory controller, waits for `mem_done`, then delivers the word and installs it. Compared with the direct-mapped generation, it adds configurable associativity and depth, per-set round-robin replacement, a single-cycle `flush` (for fence.i), and correct handling of a flush that arrives during a refill.

## Interface
- `WAYS`, 2: ways per set; must be a power of two, 1..8.
- `SETS`, 64: sets; must be a power of two, ≥2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: word width; a line is one word.
- Derived widths: `IDX_W` = log2(SETS); `TAG_W` = ADDR_W − IDX_W − 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `rdy`  in  1  global enable; when 0, all state and outputs hold.
- `req`  in  1  fetch request; held by the requester until `done`.
- `addr`  in  ADDR_W  fetch address; bits [1:0] ignored.
- `flush`  in  1  invalidate all lines.
- `data_out`  out  DATA_W  fetched word; valid in the cycle `done`=1.
- `busy`  out  1  refill in progress.
- `done`  out  1  one-cycle pulse: `data_out` is valid.
- `mem_rw_flag`  out  2  2'b01 = read; 0 otherwise.
- `mem_addr`  out  ADDR_W  refill address, word-aligned.
- `mem_len`  out  2  2'b11 (four bytes) whenever `mem_rw_flag` ≠ 0.
- `mem_data`  in  DATA_W  refill word; valid when `mem_done`=1.
- `mem_busy`  in  1  controller busy; informational, not used for control.
- `mem_done`  in  1  one-cycle pulse: refill data valid.

## Operation
- Address split: tag = addr[ADDR_W−1 : IDX_W+2]; index = addr[IDX_W+1 : 2].
- Per set and way the cache stores a valid bit, a tag and a data word. Each set also has a round-robin victim pointer of log2(WAYS) bits; it is absent when WAYS=1.
- Hit: valid and tag equal in exactly one way of the indexed set. Duplicate tags within a set must never be created.
- States are IDLE and BUSY. Reset enters IDLE.
- IDLE, `req`=1, hit: `data_out` ← hit way's data and `done` ← 1. The state stays IDLE. The replacement pointer is not changed.
- IDLE, `req`=1, miss:
  - `mem_rw_flag` ← 01, `mem_addr` ← {addr[ADDR_W−1:2], 2'b00}, `mem_len` ← 11.
  - `busy` ← 1 and the state moves to BUSY.
  - Tag, index and victim way are latched. The victim is the first invalid way (lowest number), or the pointer's way if no way is invalid.
- IDLE, `req`=0: `done` ← 0 and `mem_rw_flag` ← 0.
- BUSY: `mem_rw_flag` ← 0 from the cycle after entry. The request is a one-cycle pulse.
- BUSY with `mem_done`=1:
  - `data_out` ← `mem_data`, `done` ← 1, `busy` ← 0, and the state moves to IDLE.
  - Unless the line is marked discarded: the victim way is written with the data, the latched tag and valid=1. If the victim came from the pointer, that set's pointer increments modulo WAYS.
- Flush takes priority over lookup in IDLE. All valid bits and pointers clear in that cycle, no lookup is performed, and `done` ← 0.
- Flush in BUSY clears all valid bits and pointers and sets the discard flag. The outstanding refill still completes and is delivered, but it is not installed. The discard flag clears on leaving BUSY.
- While BUSY, changes to `req` and `addr` are ignored.
- `rst`=0 at any time (including mid-refill):
  - The state goes to IDLE immediately; all valid bits, pointers and the discard flag clear.
  - Outputs go to `data_out`=0, `busy`=0, `done`=0, `mem_rw_flag`=0, `mem_addr`=0, `mem_len`=0.
  - A later `mem_done` from a request made before reset is ignored, because the block is in IDLE.
- Data and tag arrays need not be reset; only the valid bits are.

## Timing
- Hit latency is 1 cycle: `req` is sampled at edge N and `done`=1 after edge N.
- If `req` stays high after `done`, the next edge performs a new lookup. The requester must drop `req` or change `addr` in the cycle where `done`=1.
- Miss: `mem_rw_flag`=01 for exactly one cycle, starting after the sampling edge. `done` is asserted on the edge that samples `mem_done`=1. The minimum miss latency is therefore 2 + controller latency.
- A hit to the newly installed line is possible from the cycle after `done`.
- With `rdy`=0 nothing changes, including `done` and `mem_rw_flag`. A `mem_done` pulse that arrives while `rdy`=0 is lost; the memory controller shares the same `rdy`.

## Test plan
- Reset, then fetch 0x0000_1000: a miss produces one cycle of `mem_rw_flag`=01 with `mem_addr`=0x1000. Return 0xDEADBEEF: `done` goes high with 0xDEADBEEF. Fetching 0x1000 again hits in 1 cycle with no memory request.
- WAYS=2, SETS=64: fetch 0x1000, 0x1100 and 0x1200, which share index 0. Re-fetching 0x1000 misses, because round-robin evicted way 0 for 0x1200. Re-fetching 0x1100 and 0x1200 hits.
- Fetch 0x1000 then assert `flush` for 1 cycle: re-fetching 0x1000 misses.
- Flush while BUSY refilling 0x2000: `done` still delivers the data, but a subsequent fetch of 0x2000 misses.
- Drive `rst`=0 mid-refill, then pulse `mem_done`: outputs are 0 immediately, no `done` is produced, and the first fetch after reset misses.
- Hold `rdy`=0 for 3 cycles during a hit: `done` and `data_out` hold unchanged; with `rdy`=1 operation resumes.
